// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// the default bubble instruction and the fetch FSM state encoding.
package if_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // sll $0,$0,0 encodes as all zeros, which is the MIPS NOP.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_fetch_stage_pc_next_mux.sv
// Next-PC selection: 4:1 choice between pc+4 and the three ID-stage targets,
// with a remembered redirect taking priority over the live selection.
module pc_next_mux
  import if_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [1:0]  pcsource,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic [31:0] sel_pc,
  output logic [31:0] npc
);

  // Live target chosen by the ID stage this cycle.
  always_comb begin
    sel_pc = pc4;
    case (pcsource)
      PCSRC_SEQ: sel_pc = pc4;
      PCSRC_BR:  sel_pc = bpc;
      PCSRC_JR:  sel_pc = rpc;
      PCSRC_J:   sel_pc = jpc;
      default:   sel_pc = pc4;
    endcase
  end

  // A captured redirect wins so the delay slot is followed by its target.
  always_comb begin
    npc = redir_valid ? redir_pc : sel_pc;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request
// and presents if_pc4/if_inst to an enable-less IF/ID register. Outputs are
// held stable across stalls (via inst_buf) and a NOP bubble is driven while
// memory has not answered.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_busy
);

  if_state_t   state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] inst_buf_reg;
  logic        redir_valid_reg;
  logic [31:0] redir_pc_reg;

  logic [31:0] pc4;
  logic [31:0] sel_pc;
  logic [31:0] npc;
  logic        advance;
  logic        buf_load;
  logic        capture;

  assign pc4       = pc_reg + 32'd4;
  assign if_pc4    = pc4;
  assign imem_addr = pc_reg;

  pc_next_mux u_pc_next_mux (
    .pc4         (pc4),
    .bpc         (bpc),
    .rpc         (rpc),
    .jpc         (jpc),
    .pcsource    (pcsource),
    .redir_valid (redir_valid_reg),
    .redir_pc    (redir_pc_reg),
    .sel_pc      (sel_pc),
    .npc         (npc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  // Next state, memory handshake and IF/ID outputs.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    if_inst    = NOP_INST;
    if_busy    = 1'b0;
    advance    = 1'b0;
    buf_load   = 1'b0;
    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          if_busy = 1'b1;
        end else begin
          if_inst = imem_rdata;
          if (stall) begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HOLD: begin
        if_inst = inst_buf_reg;
        if (!stall) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Remember a control transfer that ID issues while the delay slot is still
  // outstanding; only the first one is kept.
  assign capture = (pcsource != PCSRC_SEQ) && !stall && !advance && !redir_valid_reg;

  // PC, held instruction and pending-redirect registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_reg          <= RESET_PC;
      inst_buf_reg    <= 32'h0000_0000;
      redir_valid_reg <= 1'b0;
      redir_pc_reg    <= 32'h0000_0000;
    end else begin
      if (advance) begin
        pc_reg          <= npc;
        redir_valid_reg <= 1'b0;
      end else if (capture) begin
        redir_valid_reg <= 1'b1;
        redir_pc_reg    <= sel_pc;
      end
      if (buf_load) inst_buf_reg <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. A driver applies one vector per clock
// and queues the hand-computed outputs for that cycle; a monitor samples the
// DUT on the falling edge and compares against the queue head.
module tb_if_fetch_stage;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] jpc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_busy;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   vec_idx = 0;
  bit   drive_done = 1'b0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .stall      (stall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .if_pc4     (if_pc4),
    .if_inst    (if_inst),
    .if_busy    (if_busy)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic c_n, input logic st, input logic [1:0] ps,
                      input logic [31:0] b, input logic [31:0] r, input logic [31:0] j,
                      input logic rdy, input logic [31:0] rd,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_pc4, input logic [31:0] e_inst,
                      input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    clrn       = c_n;
    stall      = st;
    pcsource   = ps;
    bpc        = b;
    rpc        = r;
    jpc        = j;
    imem_ready = rdy;
    imem_rdata = rd;
    e.req  = e_req;
    e.addr = e_addr;
    e.pc4  = e_pc4;
    e.inst = e_inst;
    e.busy = e_busy;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if (imem_req !== e.req || imem_addr !== e.addr || if_pc4 !== e.pc4 ||
            if_inst !== e.inst || if_busy !== e.busy) begin
          err_cnt++;
          $display("FAIL vec%0d: got req=%b addr=%h pc4=%h inst=%h busy=%b, want req=%b addr=%h pc4=%h inst=%h busy=%b",
                   vec_idx, imem_req, imem_addr, if_pc4, if_inst, if_busy,
                   e.req, e.addr, e.pc4, e.inst, e.busy);
        end else begin
          $display("vec%0d ok: req=%b addr=%h pc4=%h inst=%h busy=%b",
                   vec_idx, imem_req, imem_addr, if_pc4, if_inst, if_busy);
        end
        vec_idx++;
      end
    end
  end

  // Directed stimulus. Argument order:
  // clrn stall pcsrc bpc rpc jpc ready rdata | req addr pc4 inst busy
  initial begin
    // In reset: FETCH at RESET_PC, memory silent -> bubble, busy.
    step(0,0,2'b00, 32'h0,32'h0,32'h0, 0,32'h0,               1,32'h0000_0000,32'h0000_0004,32'h0000_0000,1);
    // Sequential zero-wait fetch 0,4,8.
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hA000_0000,       1,32'h0000_0000,32'h0000_0004,32'hA000_0000,0);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hA000_0004,       1,32'h0000_0004,32'h0000_0008,32'hA000_0004,0);
    // pc=8 waits three cycles: bubble, busy, address held.
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 0,32'hDEAD_BEEF,       1,32'h0000_0008,32'h0000_000C,32'h0000_0000,1);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 0,32'hDEAD_BEEF,       1,32'h0000_0008,32'h0000_000C,32'h0000_0000,1);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 0,32'hDEAD_BEEF,       1,32'h0000_0008,32'h0000_000C,32'h0000_0000,1);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hA000_0008,       1,32'h0000_0008,32'h0000_000C,32'hA000_0008,0);
    // Branch to 0x100 while delay slot at C waits two cycles.
    step(1,0,2'b01, 32'h100,32'h0,32'h0, 0,32'h0,             1,32'h0000_000C,32'h0000_0010,32'h0000_0000,1);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 0,32'h0,               1,32'h0000_000C,32'h0000_0010,32'h0000_0000,1);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hA000_000C,       1,32'h0000_000C,32'h0000_0010,32'hA000_000C,0);
    // Target fetched; a zero-wait jump to 0x10.
    step(1,0,2'b11, 32'h0,32'h0,32'h10, 1,32'hA000_0100,      1,32'h0000_0100,32'h0000_0104,32'hA000_0100,0);
    // Stall four cycles on the fetch of 0x10.
    step(1,1,2'b00, 32'h0,32'h0,32'h0, 1,32'h2402_0005,       1,32'h0000_0010,32'h0000_0014,32'h2402_0005,0);
    step(1,1,2'b00, 32'h0,32'h0,32'h0, 1,32'h1111_1111,       0,32'h0000_0010,32'h0000_0014,32'h2402_0005,0);
    step(1,1,2'b00, 32'h0,32'h0,32'h0, 0,32'h2222_2222,       0,32'h0000_0010,32'h0000_0014,32'h2402_0005,0);
    step(1,1,2'b00, 32'h0,32'h0,32'h0, 1,32'h3333_3333,       0,32'h0000_0010,32'h0000_0014,32'h2402_0005,0);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'h4444_4444,       0,32'h0000_0010,32'h0000_0014,32'h2402_0005,0);
    // jr to 0x40 with zero-wait memory, then sequential 0x40 -> 0x44.
    step(1,0,2'b10, 32'h0,32'h40,32'h0, 1,32'hA000_0014,      1,32'h0000_0014,32'h0000_0018,32'hA000_0014,0);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hA000_0040,       1,32'h0000_0040,32'h0000_0044,32'hA000_0040,0);
    // Two redirects during one wait: the first (0x100) wins over the jump.
    step(1,0,2'b01, 32'h100,32'h0,32'h0, 0,32'h0,             1,32'h0000_0044,32'h0000_0048,32'h0000_0000,1);
    step(1,0,2'b11, 32'h0,32'h0,32'h80, 0,32'h0,              1,32'h0000_0044,32'h0000_0048,32'h0000_0000,1);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hA000_0044,       1,32'h0000_0044,32'h0000_0048,32'hA000_0044,0);
    // From 0x100 jump to 0x24.
    step(1,0,2'b11, 32'h0,32'h0,32'h24, 1,32'hA000_0100,      1,32'h0000_0100,32'h0000_0104,32'hA000_0100,0);
    // Wait at 0x24 with a branch captured, then reset mid-wait.
    step(1,0,2'b01, 32'h300,32'h0,32'h0, 0,32'h0,             1,32'h0000_0024,32'h0000_0028,32'h0000_0000,1);
    step(0,0,2'b00, 32'h0,32'h0,32'h0, 0,32'h0,               1,32'h0000_0000,32'h0000_0004,32'h0000_0000,1);
    // Restart at 0; the captured 0x300 must be gone.
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hB000_0000,       1,32'h0000_0000,32'h0000_0004,32'hB000_0000,0);
    // Jump to the top word: pc+4 wraps to 0, and so does the advance.
    step(1,0,2'b11, 32'h0,32'h0,32'hFFFF_FFFC, 1,32'hB000_0004, 1,32'h0000_0004,32'h0000_0008,32'hB000_0004,0);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hB000_FFFC,       1,32'hFFFF_FFFC,32'h0000_0000,32'hB000_FFFC,0);
    step(1,0,2'b00, 32'h0,32'h0,32'h0, 1,32'hB000_0000,       1,32'h0000_0000,32'h0000_0004,32'hB000_0000,0);
    drive_done = 1'b1;
  end

  // End of run: drain the queue within a bounded number of cycles.
  initial begin
    wait (drive_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Absolute time limit in case the clock or driver stalls.
  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
